// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared types and constants for the UART transmit arbiter.
//               This holds the FSM state encodings, the default result width,
//               the default busy timeout and the frame byte-count helper.
//               The FIR wrapper uses the same definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

  // Default FIR result width. The widest supported result is 40 bits.
  localparam int unsigned RES_W_DEF   = 38;
  localparam int unsigned RES_W_MAX   = 40;

  // Default number of cycles to wait for the transmitter to report busy.
  localparam int unsigned BUSY_TO_DEF = 16;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // Identifies the requester that received the most recent grant.
  typedef enum logic {
    GNT_S = 1'b0,
    GNT_R = 1'b1
  } gnt_src_e;

  // Returns the number of bytes in a frame for a result of width w,
  // which is w/8 rounded up.
  function automatic int unsigned nbytes_f(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter (R = result frame,
//               S = status byte). The grant outputs are combinational. The
//               last-grant register moves only when advance_i confirms that
//               the grant was taken. After reset the last grant is S, so R
//               wins the first tie.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import uart_tx_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_r_i,
  input  logic req_s_i,
  input  logic advance_i,
  output logic gnt_r_o,
  output logic gnt_s_o
);

  gnt_src_e last_q;
  gnt_src_e last_d;

  // Grant a lone requester outright. On a tie, favour the requester that
  // was not served last.
  always_comb begin
    gnt_r_o = 1'b0;
    gnt_s_o = 1'b0;
    if (req_r_i && req_s_i) begin
      if (last_q == GNT_S) begin
        gnt_r_o = 1'b1;
      end else begin
        gnt_s_o = 1'b1;
      end
    end else begin
      gnt_r_o = req_r_i;
      gnt_s_o = req_s_i;
    end
  end

  // Record the winner only when the grant is actually consumed.
  always_comb begin
    last_d = last_q;
    if (advance_i && gnt_r_o) begin
      last_d = GNT_R;
    end else if (advance_i && gnt_s_o) begin
      last_d = GNT_S;
    end
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GNT_S;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between the FIR result stream
//               and a status byte source. Each result is parked in a
//               one-entry holding register, sign-extended, and sent
//               MSB byte first as an NBYTES-byte frame. Whole frames
//               alternate round-robin with single status bytes, and a frame
//               is never interleaved with a status byte. RES_W must not
//               exceed 40.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned RES_W   = RES_W_DEF,
  parameter int unsigned NBYTES  = nbytes_f(RES_W),
  parameter int unsigned BUSY_TO = BUSY_TO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_data,
  input  logic             stat_valid,
  input  logic [7:0]       stat_data,
  output logic             stat_ready,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             overflow,
  output logic             frame_active
);

  localparam int unsigned FRAME_W = 8 * NBYTES;
  localparam int unsigned IDX_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CNT_W   = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TO - 1);

  // Sequencer state.
  tx_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             cur_r_q, cur_r_d;

  // Holding register and sticky drop flag.
  logic             hold_full_q, hold_full_d;
  logic [RES_W-1:0] hold_data_q, hold_data_d;
  logic             overflow_q,  overflow_d;

  // Combinational helpers.
  logic               w_req_r;
  logic               w_req_s;
  logic               w_gnt_r;
  logic               w_gnt_s;
  logic               w_advance;
  logic               w_free;
  logic               w_take;
  logic               w_drop;
  logic [FRAME_W-1:0] w_frame;
  logic [7:0]         w_bytes [NBYTES];
  logic [IDX_W-1:0]   w_sel_idx;
  logic [7:0]         w_sel_byte;

  // Arbitration happens only while idle with the transmitter free. Gating
  // the requests here keeps the arbiter from granting mid-frame.
  assign w_req_r = hold_full_q && (state_q == ST_IDLE) && !tx_busy;
  assign w_req_s = stat_valid  && (state_q == ST_IDLE) && !tx_busy;

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (clk),
    .rst_n     (rst),
    .req_r_i   (w_req_r),
    .req_s_i   (w_req_s),
    .advance_i (w_advance),
    .gnt_r_o   (w_gnt_r),
    .gnt_s_o   (w_gnt_s)
  );

  // Sign-extend the held result to a whole number of bytes.
  if (FRAME_W > RES_W) begin : g_sext
    assign w_frame = {{(FRAME_W - RES_W){hold_data_q[RES_W-1]}}, hold_data_q};
  end else begin : g_noext
    assign w_frame = hold_data_q;
  end

  // Byte k of the frame is taken MSB first: byte 0 is the top byte.
  for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
    assign w_bytes[g] = w_frame[8*(NBYTES-1-g) +: 8];
  end

  // The serializer picks byte 0 when a frame is granted. Between bytes it
  // picks the byte after the current one. Out-of-range values at the end of
  // the frame are never loaded.
  assign w_sel_idx  = (state_q == ST_WAIT_DONE) ? idx_q + 1'b1 : '0;
  assign w_sel_byte = w_bytes[w_sel_idx];

  // Next-state, byte loading and frame bookkeeping for the sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    cur_r_d   = cur_r_q;
    w_advance = 1'b0;
    w_free    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_gnt_r || w_gnt_s) begin
          w_advance = 1'b1;
          state_d   = ST_START;
          idx_d     = '0;
          cur_r_d   = w_gnt_r;
          tx_data_d = w_gnt_r ? w_sel_byte : stat_data;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        // A transmitter that never reports busy is treated as having sent
        // the byte, so one missing busy pulse cannot stall a frame.
        if (tx_busy || (cnt_q == TO_LAST)) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (cur_r_q && (idx_q != LAST_IDX)) begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = w_sel_byte;
            state_d   = ST_START;
          end else begin
            idx_d   = '0;
            w_free  = cur_r_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A result capture is allowed into an empty register, or into one that is
  // being freed in this same cycle. Otherwise the incoming word is lost.
  assign w_take = res_valid && (!hold_full_q || w_free);
  assign w_drop = res_valid &&  hold_full_q && !w_free;

  // Holding register occupancy, capture and sticky overflow.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    overflow_d  = overflow_q | w_drop;
    if (w_free) begin
      hold_full_d = 1'b0;
    end
    if (w_take) begin
      hold_full_d = 1'b1;
      hold_data_d = res_data;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      cur_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      cur_r_q   <= cur_r_d;
    end
  end

  // Holding register and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // The grant-cycle outputs are combinational. They are qualified with the
  // reset so that they drop in the same cycle the reset is asserted.
  assign tx_start     = (state_q == ST_START);
  assign tx_data      = tx_data_q;
  assign overflow     = overflow_q;
  assign stat_ready   = rst & w_gnt_s;
  assign frame_active = rst & (((state_q != ST_IDLE) && cur_r_q) || w_gnt_r);

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter, with a
//               simple UART transmitter model that logs every started byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        res_valid = 1'b0;
  logic [37:0] res_data = '0;
  logic        stat_valid;
  logic [7:0]  stat_data = 8'h00;
  logic        stat_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        overflow;
  logic        frame_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // UART model state
  logic       m_busy = 1'b0;
  logic       busy_ovr = 1'b0;
  bit         busy_mode = 1'b1;
  int         m_rise = 0;
  int         m_hold = 0;
  int         stab_err = 0;
  logic [7:0] held = 8'h00;
  logic [7:0] log_d [0:127];
  int         log_c [0:127];
  int         log_n = 0;

  // Status request handshake: the tasks raise a request, and the acceptor clears it
  int stat_set_n = 0;
  int stat_clr_n = 0;

  assign tx_busy    = m_busy | busy_ovr;
  assign stat_valid = (stat_set_n != stat_clr_n);

  uart_tx_arbiter #(.RES_W(38), .NBYTES(5), .BUSY_TO(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .stat_valid   (stat_valid),
    .stat_data    (stat_data),
    .stat_ready   (stat_ready),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .overflow     (overflow),
    .frame_active (frame_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises 2 cycles after start and is held for 20
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      m_busy = 1'b0;
      m_rise = 0;
      m_hold = 0;
    end else begin
      if (tx_start) begin
        if (log_n < 128) begin
          log_d[log_n] = tx_data;
          log_c[log_n] = cyc;
        end
        log_n++;
        held = tx_data;
        if (busy_mode) m_rise = 2;
      end else if (m_rise > 0) begin
        m_rise--;
        if (m_rise == 0) begin
          m_busy = 1'b1;
          m_hold = 20;
        end
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_busy = 1'b0;
      end
      if (m_busy && (tx_data !== held)) stab_err++;
    end
  end

  // Status acceptor: drop the request after the edge that accepted it
  always @(posedge clk) begin
    bit acc;
    acc = stat_valid && stat_ready;
    #1;
    if (acc) stat_clr_n++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_res(input logic [37:0] d);
    res_data  = d;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int target, input int budget, input string tag);
    int k = 0;
    while (k < budget && !(log_n >= target && m_rise == 0 && m_busy == 1'b0 && frame_active == 1'b0)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s timeout: bytes seen %0d, required %0d", tag, log_n, target);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
    checks++; if (stat_ready !== 1'b0) begin errors++; $display("FAIL reset_stat_ready: got %b required 0", stat_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active: got %b required 0", frame_active); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_status();
    int b = log_n;
    busy_ovr  = 1'b1;
    stat_data = 8'h5A;
    stat_set_n++;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stat_ready !== 1'b0) begin errors++; $display("FAIL busy_idle_no_grant: got %b required 0", stat_ready); end
    checks++; if (log_n !== b) begin errors++; $display("FAIL busy_idle_no_start: got %0d required %0d", log_n, b); end
    busy_ovr = 1'b0;
    #1;
    checks++; if (stat_ready !== 1'b1) begin errors++; $display("FAIL stat_ready_grant: got %b required 1", stat_ready); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL stat_start_latency: got %b required 1", tx_start); end
    checks++; if (tx_data !== 8'h5A) begin errors++; $display("FAIL stat_tx_data: got %h required 5a", tx_data); end
    checks++; if (stat_ready !== 1'b0) begin errors++; $display("FAIL stat_ready_pulse: got %b required 0", stat_ready); end
    wait_quiet(b + 1, 200, "status");
    checks++; if (log_n !== b + 1) begin errors++; $display("FAIL status_count: got %0d required %0d", log_n - b, 1); end
  endtask

  task automatic test_single();
    logic [7:0] exp [5] = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    int b = log_n;
    int t0 = cyc;
    int k;
    pulse_res(38'h00_1234_5678);
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL single_grant_frame_active: got %b required 1", frame_active); end
    k = 0;
    while (k < 20 && log_n <= b) begin @(negedge clk); k++; end
    checks++; if (log_n <= b || log_c[b] - t0 != 2) begin errors++; $display("FAIL single_latency: got %0d required 2", log_c[b] - t0); end
    k = 0;
    while (k < 600 && !(log_n >= b + 5 && tx_busy)) begin @(negedge clk); k++; end
    while (k < 600 && tx_busy) begin @(negedge clk); k++; end
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL single_active_last_fall: got %b required 1", frame_active); end
    @(negedge clk);
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL single_active_end: got %b required 0", frame_active); end
    wait_quiet(b + 5, 100, "single");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_d[b+i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h required %h", i, log_d[b+i], exp[i]); end
    end
    checks++; if (log_n !== b + 5) begin errors++; $display("FAIL single_count: got %0d required 5", log_n - b); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_negative();
    logic [7:0] exp [5] = '{8'hE0, 8'h00, 8'h00, 8'h00, 8'h01};
    int b = log_n;
    pulse_res(38'h20_0000_0001);
    wait_quiet(b + 5, 600, "negative");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_d[b+i] !== exp[i]) begin errors++; $display("FAIL neg_byte%0d: got %h required %h", i, log_d[b+i], exp[i]); end
    end
  endtask

  task automatic test_tie();
    logic [7:0] exp1 [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hA5};
    logic [7:0] exp2 [6] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    int b;
    // Serve a lone status byte so that the last grant is S
    b = log_n;
    stat_data = 8'h11;
    stat_set_n++;
    wait_quiet(b + 1, 200, "tie_prep_s");
    // First tie: R was not served last, so the frame goes first
    b = log_n;
    pulse_res(38'h01_0203_0405);
    stat_data = 8'hA5;
    stat_set_n++;
    #1;
    checks++; if (frame_active !== 1'b1 || stat_ready !== 1'b0) begin errors++; $display("FAIL tie1_grant: got fa=%b sr=%b required fa=1 sr=0", frame_active, stat_ready); end
    wait_quiet(b + 6, 900, "tie1");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_d[b+i] !== exp1[i]) begin errors++; $display("FAIL tie1_byte%0d: got %h required %h", i, log_d[b+i], exp1[i]); end
    end
    // Serve a lone frame so that the last grant is R
    b = log_n;
    pulse_res(38'h00_0000_0077);
    wait_quiet(b + 5, 600, "tie_prep_r");
    // Second tie: S was not served last, so A5 goes first
    b = log_n;
    pulse_res(38'h3F_FFFF_FFFE);
    stat_data = 8'hA5;
    stat_set_n++;
    #1;
    checks++; if (frame_active !== 1'b0 || stat_ready !== 1'b1) begin errors++; $display("FAIL tie2_grant: got fa=%b sr=%b required fa=0 sr=1", frame_active, stat_ready); end
    wait_quiet(b + 6, 900, "tie2");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_d[b+i] !== exp2[i]) begin errors++; $display("FAIL tie2_byte%0d: got %h required %h", i, log_d[b+i], exp2[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] expa [5] = '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h55};
    logic [7:0] expe [5] = '{8'h1F, 8'h00, 8'h00, 8'h00, 8'hEE};
    int b = log_n;
    int k;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b required 0", overflow); end
    pulse_res(38'h00_AAAA_5555);
    repeat (10) @(negedge clk);
    pulse_res(38'h11_1111_1111);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
    repeat (10) @(negedge clk);
    pulse_res(38'h22_2222_2222);
    wait_quiet(b + 5, 600, "overflow_frame");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_d[b+i] !== expa[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h required %h", i, log_d[b+i], expa[i]); end
    end
    repeat (40) @(negedge clk);
    checks++; if (log_n !== b + 5) begin errors++; $display("FAIL ovf_dropped_not_sent: got %0d required 5", log_n - b); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    // Capture in the same cycle as the holding register frees
    b = log_n;
    pulse_res(38'h00_DDDD_0001);
    k = 0;
    while (k < 600 && !(log_n >= b + 5 && tx_busy)) begin @(negedge clk); k++; end
    while (k < 600 && tx_busy) begin @(negedge clk); k++; end
    pulse_res(38'h1F_0000_00EE);
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL free_cycle_capture: got %b required 1", frame_active); end
    wait_quiet(b + 10, 800, "free_cycle");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_d[b+5+i] !== expe[i]) begin errors++; $display("FAIL free_byte%0d: got %h required %h", i, log_d[b+5+i], expe[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [5] = '{8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h12};
    int b = log_n;
    busy_mode = 1'b0;
    pulse_res(38'h0A_BCDE_F012);
    wait_quiet(b + 5, 400, "timeout");
    checks++; if (log_n !== b + 5) begin errors++; $display("FAIL to_count: got %0d required 5", log_n - b); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_d[b+i] !== exp[i]) begin errors++; $display("FAIL to_byte%0d: got %h required %h", i, log_d[b+i], exp[i]); end
    end
    checks++; if (log_c[b+1] - log_c[b] != 18) begin errors++; $display("FAIL to_gap_first: got %0d required 18", log_c[b+1] - log_c[b]); end
    checks++; if (log_c[b+4] - log_c[b+3] != 18) begin errors++; $display("FAIL to_gap_last: got %0d required 18", log_c[b+4] - log_c[b+3]); end
    busy_mode = 1'b1;
  endtask

  task automatic test_reset_mid();
    int b = log_n;
    int k = 0;
    pulse_res(38'h00_1111_2222);
    while (k < 400 && log_n < b + 3) begin @(negedge clk); k++; end
    rst = 1'b0;
    stat_data = 8'h3C;
    stat_set_n++;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_start: got %b required 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_tx_data: got %h required 00", tx_data); end
    checks++; if (stat_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_stat_ready: got %b required 0", stat_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow: got %b required 0", overflow); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_active: got %b required 0", frame_active); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    b = log_n;
    wait_quiet(b + 1, 200, "post_reset");
    checks++; if (log_d[b] !== 8'h3C) begin errors++; $display("FAIL post_rst_byte: got %h required 3c", log_d[b]); end
    repeat (60) @(negedge clk);
    checks++; if (log_n !== b + 1) begin errors++; $display("FAIL post_rst_no_resume: got %0d required 1", log_n - b); end
    checks++; if (stat_valid !== 1'b0) begin errors++; $display("FAIL post_rst_stat_accepted: got %b required 0", stat_valid); end
  endtask

  initial begin
    test_reset();
    test_status();
    test_single();
    test_negative();
    test_tie();
    test_overflow();
    test_timeout();
    test_reset_mid();
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL tx_data_stable: got %0d changes required 0", stab_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
